// File: rtl/unsigned_mul_8x8_ha_seq_ctrl.sv
// Sequential controller for an external 8x8 half-adder-array multiplier: it captures
// the operands, accumulates the four weighted row vectors the array returns, and holds the product.
module unsigned_mul_8x8_ha_seq_ctrl #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  mul_x,
    output logic [7:0]  mul_y,
    input  logic [6:0]  ha_0_b,
    input  logic [8:0]  ha_0_t,
    input  logic [6:0]  ha_1_b,
    input  logic [8:0]  ha_1_t,
    input  logic [6:0]  ha_2_b,
    input  logic [8:0]  ha_2_t,
    input  logic [6:0]  ha_3_b,
    input  logic [8:0]  ha_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_ovf,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready depends combinationally on out_ready only in DONE, so a product can be
    // handed off and new operands taken on the same edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int LAST_IDX = NUM_ROWS - ROWS_PER_CYCLE;

    generate
        if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
            $fatal(1, "ROWS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [17:0] acc_q, acc_d;
    logic [7:0]  mul_x_q, mul_x_d;
    logic [7:0]  mul_y_q, mul_y_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_p_q, out_p_d;
    logic        out_ovf_q, out_ovf_d;
    logic        busy_q, busy_d;

    logic [17:0] row_term [NUM_ROWS];
    logic [17:0] add_sum;
    logic [17:0] acc_next;
    logic        accept;

    // Carry vector sits two bit positions above the sum vector; row k is shifted by 2k.
    always_comb begin
        row_term[0] =  18'(ha_0_t) + (18'(ha_0_b) << 2);
        row_term[1] = (18'(ha_1_t) + (18'(ha_1_b) << 2)) << 2;
        row_term[2] = (18'(ha_2_t) + (18'(ha_2_b) << 2)) << 4;
        row_term[3] = (18'(ha_3_t) + (18'(ha_3_b) << 2)) << 6;
    end

    always_comb begin
        add_sum = '0;
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            add_sum = add_sum + row_term[idx_q + 2'(r)];
        end
    end

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_ovf_d   = out_ovf_q;
        busy_d      = busy_q;
        acc_next    = acc_q + add_sum;

        case (state_q)
            S_ACC: begin
                acc_d = acc_next;
                idx_d = idx_q + 2'(ROWS_PER_CYCLE);
                if (idx_q == 2'(LAST_IDX)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_p_d     = acc_next[15:0];
                    out_ovf_d   = |acc_next[17:16];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept overrides the DONE->IDLE exit so back-to-back products have no bubble.
        if (accept) begin
            state_d     = S_ACC;
            mul_x_d     = in_x;
            mul_y_d     = in_y;
            acc_d       = '0;
            idx_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_ovf_q   <= out_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_seq_ctrl.sv
// Bench for unsigned_mul_8x8_ha_seq_ctrl: a behavioural array model feeds the rows, and a
// transaction-level model predicts handshakes and products for a ROWS_PER_CYCLE=1 and a =4 instance.
`timescale 1ns/1ps
module tb_unsigned_mul_8x8_ha_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready;
    logic [7:0]  in_x, in_y;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [7:0]  mul_x, mul_y;
    logic [15:0] out_p;
    logic [1:0]  dbg_state;
    logic [6:0]  hb [4];
    logic [8:0]  ht [4];

    logic        in_valid4, out_ready4;
    logic [7:0]  in_x4, in_y4;
    logic        in_ready4, out_valid4, out_ovf4, busy4;
    logic [7:0]  mul_x4, mul_y4;
    logic [15:0] out_p4;
    logic [1:0]  dbg_state4;
    logic [6:0]  hb4 [4];
    logic [8:0]  ht4 [4];

    int ha_mode;  // 0: exact partial products, 1: all ones, 2: hashed pattern
    int total = 0;
    int bad   = 0;

    unsigned_mul_8x8_ha_seq_ctrl #(.ROWS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .mul_x(mul_x), .mul_y(mul_y),
        .ha_0_b(hb[0]), .ha_0_t(ht[0]), .ha_1_b(hb[1]), .ha_1_t(ht[1]),
        .ha_2_b(hb[2]), .ha_2_t(ht[2]), .ha_3_b(hb[3]), .ha_3_t(ht[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_ovf(out_ovf), .busy(busy), .dbg_state(dbg_state)
    );

    unsigned_mul_8x8_ha_seq_ctrl #(.ROWS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_x(in_x4), .in_y(in_y4), .mul_x(mul_x4), .mul_y(mul_y4),
        .ha_0_b(hb4[0]), .ha_0_t(ht4[0]), .ha_1_b(hb4[1]), .ha_1_t(ht4[1]),
        .ha_2_b(hb4[2]), .ha_2_t(ht4[2]), .ha_3_b(hb4[3]), .ha_3_t(ht4[3]),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_p(out_p4),
        .out_ovf(out_ovf4), .busy(busy4), .dbg_state(dbg_state4)
    );

    // Row k of the array as {carry[6:0], sum[8:0]}.
    function automatic logic [15:0] ha_row(input logic [7:0] x, input logic [7:0] y,
                                           input int mode, input int k);
        logic [6:0] b;
        logic [8:0] t;
        int p, h, q;
        case (mode)
            1: begin
                b = '1;
                t = '1;
            end
            2: begin
                h = int'(x) * 37 + int'(y) * 11 + k * 91;
                q = int'(x ^ y) + k * 13;
                t = h[8:0];
                b = q[6:0];
            end
            default: begin
                p = int'(x) * ((int'(y) >> (2 * k)) & 3);
                q = (p / 4 > 127) ? 127 : p / 4;
                h = p - 4 * q;
                b = q[6:0];
                t = h[8:0];
            end
        endcase
        return {b, t};
    endfunction

    // Expected accumulated value from the per-bit weights of every returned row bit.
    function automatic int model_sum(input logic [7:0] x, input logic [7:0] y, input int mode);
        int s;
        logic [15:0] row;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            row = ha_row(x, y, mode, k);
            for (int i = 0; i < 9; i++) if (row[i]) s += (1 << (2 * k + i));
            for (int i = 0; i < 7; i++) if (row[9 + i]) s += (1 << (2 * k + i + 2));
        end
        return s;
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            {hb[k], ht[k]}   = ha_row(mul_x, mul_y, ha_mode, k);
            {hb4[k], ht4[k]} = ha_row(mul_x4, mul_y4, 0, k);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the R=1 instance: phase 0 idle, 1 accumulating, 2 holding.
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_exp   = 0;
    bit         m_known = 1'b0;
    bit         m_fresh = 1'b0;
    logic [7:0] m_mx = '0, m_my = '0;

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("out_valid", int'(out_valid), int'(m_phase == 2));
            chk("in_ready", int'(in_ready), int'(m_phase == 0 || (m_phase == 2 && out_ready)));
            chk("mul_x", int'(mul_x), int'(m_mx));
            chk("mul_y", int'(mul_y), int'(m_my));
            if (m_phase == 2) begin
                chk("out_p", int'(out_p), m_exp % 65536);
                chk("out_ovf", int'(out_ovf), int'(m_exp > 65535));
            end
            if (m_fresh) begin
                chk("rst_out_p", int'(out_p), 0);
                chk("rst_out_ovf", int'(out_ovf), 0);
            end
        end
        if (rst) begin
            m_known = 1'b1;
            m_fresh = 1'b1;
            m_phase = 0;
            m_mx    = '0;
            m_my    = '0;
        end else if (m_known) begin
            case (m_phase)
                0: if (in_valid) model_accept();
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) begin
                    if (in_valid) model_accept();
                    else m_phase = 0;
                end
            endcase
        end
    end

    function automatic void model_accept();
        m_phase = 1;
        m_left  = 4;
        m_mx    = in_x;
        m_my    = in_y;
        m_exp   = model_sum(in_x, in_y, ha_mode);
        m_fresh = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles waited after the accept edge; a blown budget is a failed comparison.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        if (!out_valid) chk("timeout_out_valid", 0, 1);
    endtask

    task automatic do_accept(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
    endtask

    int n;
    logic [7:0] nx, ny, rx, ry;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_x4 = '0; in_y4 = '0;
        ha_mode = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("first_in_ready", int'(in_ready), 1);
        step();

        // 3 x 3 with exact rows: product 9 four cycles after accept.
        do_accept(8'd3, 8'd3);
        wait_valid(n);
        chk("lat_3x3", n, 4);
        chk("p_3x3", int'(out_p), 9);
        chk("ovf_3x3", int'(out_ovf), 0);
        drain();

        // Every row bit set: weighted sum 86615 = 0x15257.
        ha_mode = 1;
        do_accept(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_valid(n);
        chk("ones_p", int'(out_p), 'h5257);
        chk("ones_ovf", int'(out_ovf), 1);
        drain();

        // Consumer stalls in DONE while new operands wait, then a same-edge handoff.
        ha_mode = 2;
        do_accept(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_valid(n);
        nx = 8'($urandom_range(0, 255));
        ny = 8'($urandom_range(0, 255));
        in_valid = 1'b1; in_x = nx; in_y = ny;
        repeat (5) step();
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("handoff_busy", int'(busy), 1);
        chk("handoff_mul_x", int'(mul_x), int'(nx));
        chk("handoff_out_valid", int'(out_valid), 0);
        wait_valid(n);
        drain();

        // Reset two accumulation edges into a product; nothing stale may appear later.
        do_accept(8'd200, 8'd77);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_mul_x", int'(mul_x), 0);
        chk("rst_mid_busy", int'(busy), 0);
        out_ready = 1'b1;
        repeat (8) step();
        out_ready = 1'b0;

        // Random traffic: in_valid toggles during accumulation, consumer stalls at random.
        for (int seg = 0; seg < 2; seg++) begin
            ha_mode = (seg == 0) ? 0 : 2;
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_x      = 8'($urandom);
                in_y      = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            drain();
        end

        // ROWS_PER_CYCLE=4 instance: product one cycle after accept.
        in_valid4 = 1'b1; in_x4 = 8'd0; in_y4 = 8'hFF;
        step();
        in_valid4 = 1'b0;
        step();
        chk("r4_valid", int'(out_valid4), 1);
        chk("r4_p_zero", int'(out_p4), 0);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            in_valid4 = 1'b1; in_x4 = rx; in_y4 = ry;
            step();
            in_valid4 = 1'b0;
            chk("r4_busy", int'(busy4), 1);
            step();
            chk("r4_valid_rand", int'(out_valid4), 1);
            chk("r4_p_rand", int'(out_p4), int'(rx) * int'(ry));
            chk("r4_ovf_rand", int'(out_ovf4), 0);
            out_ready4 = 1'b1;
            step();
            out_ready4 = 1'b0;
            chk("r4_idle", int'(out_valid4), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
